// File: rtl/tama_input_conditioner_if.sv
// tama_input_conditioner_if: raw board inputs and conditioned single-cycle event outputs
interface tama_input_conditioner_if;
  logic btn_feed_n, btn_heal_n, btn_mode_n, light_raw, echo_in;
  logic trig, feeding, healing, light_out, change_state, test, echo_sig;
  modport master(
    output btn_feed_n, btn_heal_n, btn_mode_n, light_raw, echo_in,
    input  trig, feeding, healing, light_out, change_state, test, echo_sig
  );
  modport slave(
    input  btn_feed_n, btn_heal_n, btn_mode_n, light_raw, echo_in,
    output trig, feeding, healing, light_out, change_state, test, echo_sig
  );
endinterface

// File: rtl/tama_input_conditioner.sv
// tama_input_conditioner: sync/debounce board inputs, split mode presses, run ultrasonic ranging
module tama_input_conditioner #(
  parameter int DEB_CYCLES    = 4,
  parameter int LONG_CYCLES   = 250,
  parameter int TRIG_CYCLES   = 10,
  parameter int ECHO_TIMEOUT  = 2000,
  parameter int NEAR_CYCLES   = 100,
  parameter int PERIOD_CYCLES = 5000,
  parameter int CNT_W         = 16
) (
  input logic clk,
  input logic rst,
  tama_input_conditioner_if.slave io
);
  typedef enum logic [1:0] {M_IDLE, M_PRESS, M_LONG} mode_t;
  typedef enum logic [1:0] {U_TRIG, U_WAIT, U_MEAS, U_GAP} rng_t;
  localparam logic [CNT_W-1:0] DEB_M1  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIG_W  = CNT_W'(TRIG_CYCLES);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] NEAR_W  = CNT_W'(NEAR_CYCLES);
  localparam logic [CNT_W-1:0] PER_M1  = CNT_W'(PERIOD_CYCLES - 1);
  // channel order: 0 feed, 1 heal, 2 mode, 3 light; all idle high
  logic [3:0] raw, s1, s2, stb, acc, fall, rise;
  logic [3:0][CNT_W-1:0] deb;
  logic [2:0] es;
  logic echo, echo_rise;
  mode_t ms, ms_nx;
  rng_t us, us_nx;
  logic [CNT_W-1:0] hold, hold_nx, pc, pc_nx, w, w_nx;
  logic near, near_nx, trig_nx, esig_nx, test_nx, chg_nx;
  assign raw = {io.light_raw, io.btn_mode_n, io.btn_heal_n, io.btn_feed_n};
  assign fall = acc & ~s2;
  assign rise = acc & s2;
  assign echo = es[1];
  assign echo_rise = es[1] & ~es[2];
  always_comb begin
    acc = '0;
    for (int i = 0; i < 4; i++) acc[i] = (s2[i] != stb[i]) && (deb[i] == DEB_M1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '1;
      s2 <= '1;
      stb <= '1;
      deb <= '0;
      es <= '0;
      io.feeding <= 1'b0;
      io.healing <= 1'b0;
      io.light_out <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stb <= (stb & ~acc) | (s2 & acc);
      for (int i = 0; i < 4; i++) deb[i] <= (s2[i] == stb[i] || acc[i]) ? '0 : deb[i] + 1'b1;
      es <= {es[1:0], io.echo_in};
      io.feeding <= fall[0];
      io.healing <= fall[1];
      io.light_out <= fall[3];
    end
  always_comb begin
    ms_nx = ms;
    hold_nx = hold;
    test_nx = 1'b0;
    chg_nx = 1'b0;
    case (ms)
      M_IDLE: if (fall[2]) begin
        ms_nx = M_PRESS;
        hold_nx = '0;
      end
      M_PRESS: if (hold == LONG_M1) begin
        test_nx = 1'b1;
        ms_nx = M_LONG;
      end else if (rise[2]) begin
        chg_nx = 1'b1;
        ms_nx = M_IDLE;
      end else hold_nx = hold + 1'b1;
      M_LONG: ms_nx = rise[2] ? M_IDLE : M_LONG;
      default: ms_nx = M_IDLE;
    endcase
  end
  // width counts the rise sample itself, so w equals the echo-high cycle count at the fall
  always_comb begin
    us_nx = us;
    pc_nx = pc + 1'b1;
    w_nx = w;
    near_nx = near;
    trig_nx = 1'b0;
    esig_nx = 1'b0;
    case (us)
      U_TRIG: begin
        w_nx = '0;
        if (pc == TRIG_W) us_nx = U_WAIT;
        else trig_nx = 1'b1;
      end
      U_WAIT: if (echo_rise) begin
        us_nx = U_MEAS;
        w_nx = CNT_W'(1);
      end else if (w == TO_M1) begin
        us_nx = U_GAP;
        near_nx = 1'b0;
      end else w_nx = w + 1'b1;
      U_MEAS: if (!echo) begin
        us_nx = U_GAP;
        near_nx = w < NEAR_W;
        esig_nx = (w < NEAR_W) && !near;
      end else if (w == TO_M1) begin
        us_nx = U_GAP;
        near_nx = 1'b0;
      end else w_nx = w + 1'b1;
      U_GAP: if (pc == PER_M1) begin
        us_nx = U_TRIG;
        pc_nx = '0;
      end
      default: us_nx = U_TRIG;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ms <= M_IDLE;
      hold <= '0;
      us <= U_TRIG;
      pc <= '0;
      w <= '0;
      near <= 1'b0;
      io.trig <= 1'b0;
      io.echo_sig <= 1'b0;
      io.test <= 1'b0;
      io.change_state <= 1'b0;
    end else begin
      ms <= ms_nx;
      hold <= hold_nx;
      us <= us_nx;
      pc <= pc_nx;
      w <= w_nx;
      near <= near_nx;
      io.trig <= trig_nx;
      io.echo_sig <= esig_nx;
      io.test <= test_nx;
      io.change_state <= chg_nx;
    end
endmodule
